seq_restoring_divider: RTL and testbench



---
 rtl/seq_restoring_divider.sv | 138 +++++++++++++
 tb/tb_seq_restoring_divider.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider
//   Iterative unsigned restoring divider. Resolves BITS_PER_CYCLE quotient
//   bits per clock with a chain of trial-subtract/restore steps, MSB first.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   in_valid     operands valid
//   in_ready     divider idle, can accept operands
//   dividend     unsigned dividend  [WIDTH]
//   divisor      unsigned divisor   [WIDTH]
//   out_valid    result valid (held until out_ready)
//   out_ready    consumer accepts result
//   quotient     unsigned quotient  [WIDTH]
//   remainder    unsigned remainder [WIDTH]
//   div_by_zero  divisor was zero for this result
//
// Divide-by-zero returns quotient = all ones, remainder = dividend.
module seq_restoring_divider #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS + 1);

  if (WIDTH < 2) begin : g_bad_width
    $error("seq_restoring_divider: WIDTH must be 2 or more");
  end
  if (WIDTH % BITS_PER_CYCLE != 0) begin : g_bad_bpc
    $error("seq_restoring_divider: BITS_PER_CYCLE must divide WIDTH");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] rem_reg;      // partial remainder, always < divisor
  logic [WIDTH-1:0] shift_reg;    // dividend bits shift out MSB, quotient bits shift in LSB
  logic [WIDTH-1:0] divisor_reg;
  logic [CNT_W-1:0] count_reg;

  // Step chain: element 0 is the registered state, element k is the state
  // after k trial-subtract/restore steps within this clock.
  logic [WIDTH-1:0] rem_chain [BITS_PER_CYCLE+1];
  logic [WIDTH-1:0] q_chain   [BITS_PER_CYCLE+1];

  assign rem_chain[0] = rem_reg;
  assign q_chain[0]   = shift_reg;

  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           borrow;

    assign shifted = {rem_chain[gi], q_chain[gi][WIDTH-1]};
    // shifted < 2*divisor, so on WIDTH+1 bits the MSB of the difference is
    // set exactly when shifted < divisor (the subtraction wrapped).
    assign diff   = shifted - {1'b0, divisor_reg};
    assign borrow = diff[WIDTH];
    // On borrow, shifted < divisor < 2^WIDTH, so its low WIDTH bits are exact.
    assign rem_chain[gi+1] = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    assign q_chain[gi+1]   = {q_chain[gi][WIDTH-2:0], ~borrow};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      count_reg   <= '0;
      rem_reg     <= '0;
      shift_reg   <= '0;
      divisor_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            divisor_reg <= divisor;
            in_ready    <= 1'b0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state_reg   <= DONE;
            end else begin
              rem_reg   <= '0;
              shift_reg <= dividend;
              count_reg <= CNT_W'(STEPS);
              state_reg <= CALC;
            end
          end
        end
        CALC: begin
          rem_reg   <= rem_chain[BITS_PER_CYCLE];
          shift_reg <= q_chain[BITS_PER_CYCLE];
          count_reg <= count_reg - CNT_W'(1);
          // Last group of bits: publish the result on the same edge.
          if (count_reg == CNT_W'(1)) begin
            quotient    <= q_chain[BITS_PER_CYCLE];
            remainder   <= rem_chain[BITS_PER_CYCLE];
            div_by_zero <= 1'b0;
            out_valid   <= 1'b1;
            state_reg   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider
//   Drives an 8-bit/1-bit-per-cycle divider and a 16-bit/4-bits-per-cycle
//   divider. Expected results are pushed to a queue when operands are
//   accepted and popped when the divider presents its result.
module tb_seq_restoring_divider;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic        in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0, dbz8;
  logic [7:0]  dividend8 = '0, divisor8 = '0, quotient8, remainder8;
  // 16-bit instance
  logic        in_valid16 = 1'b0, in_ready16, out_valid16, out_ready16 = 1'b0, dbz16;
  logic [15:0] dividend16 = '0, divisor16 = '0, quotient16, remainder16;

  seq_restoring_divider #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .dividend(dividend8), .divisor(divisor8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .quotient(quotient8), .remainder(remainder8), .div_by_zero(dbz8)
  );

  seq_restoring_divider #(.WIDTH(16), .BITS_PER_CYCLE(4)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .dividend(dividend16), .divisor(divisor16),
    .out_valid(out_valid16), .out_ready(out_ready16),
    .quotient(quotient16), .remainder(remainder16), .div_by_zero(dbz16)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] q;
    logic [15:0] r;
    logic        z;
    int          lat;
  } exp_t;

  exp_t sb8[$];
  exp_t sb16[$];

  int errors = 0;
  int checks = 0;

  // ------------------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({in_ready8, out_valid8, quotient8, remainder8, dbz8} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset8: got rdy=%b vld=%b q=%0d r=%0d z=%b want rdy=1 vld=0 q=0 r=0 z=0",
               in_ready8, out_valid8, quotient8, remainder8, dbz8);
    end
    checks++;
    if ({in_ready16, out_valid16, quotient16, remainder16, dbz16} !== {1'b1, 1'b0, 16'h0, 16'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset16: got rdy=%b vld=%b q=%0d r=%0d z=%b want rdy=1 vld=0 q=0 r=0 z=0",
               in_ready16, out_valid16, quotient16, remainder16, dbz16);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One 8-bit transaction; hold = cycles out_ready stays low after out_valid.
  // Called at posedge+1.
  task automatic do_div8(input string tag, input logic [7:0] a, input logic [7:0] b, input int hold);
    exp_t e;
    int lat;
    logic [7:0] sq, sr;
    logic sz;
    e.a = {8'h00, a};
    e.b = {8'h00, b};
    if (b == 8'd0) begin
      e.q = 16'h00FF; e.r = {8'h00, a}; e.z = 1'b1; e.lat = 1;
    end else begin
      e.q = {8'h00, a / b}; e.r = {8'h00, a % b}; e.z = 1'b0; e.lat = 9;
    end
    sb8.push_back(e);

    checks++;
    if (in_ready8 !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready_before_accept: got %b want 1", tag, in_ready8);
    end
    in_valid8 = 1'b1; dividend8 = a; divisor8 = b;
    @(posedge clk);
    #1;
    // Operands are captured on the accept edge; scramble them afterwards.
    in_valid8 = 1'b0; dividend8 = 8'($urandom); divisor8 = 8'($urandom);
    lat = 1;
    while (out_valid8 !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat != e.lat) begin
      errors++;
      $display("FAIL %s latency: got %0d edges want %0d", tag, lat, e.lat);
    end

    sq = quotient8; sr = remainder8; sz = dbz8;
    for (int i = 0; i < hold; i++) begin
      // Mid-window operand pulse must be ignored while the result is pending.
      in_valid8 = (i == 2);
      dividend8 = 8'd1; divisor8 = 8'd1;
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid8, in_ready8, quotient8, remainder8, dbz8} !== {1'b1, 1'b0, sq, sr, sz}) begin
        errors++;
        $display("FAIL %s hold_stable[%0d]: got vld=%b rdy=%b q=%0d r=%0d z=%b want vld=1 rdy=0 q=%0d r=%0d z=%b",
                 tag, i, out_valid8, in_ready8, quotient8, remainder8, dbz8, sq, sr, sz);
      end
    end
    in_valid8 = 1'b0;

    e = sb8.pop_front();
    checks++;
    if ({quotient8, remainder8, dbz8} !== {e.q[7:0], e.r[7:0], e.z}) begin
      errors++;
      $display("FAIL %s result %0d/%0d: got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
               tag, e.a, e.b, quotient8, remainder8, dbz8, e.q, e.r, e.z);
    end
    out_ready8 = 1'b1;
    @(posedge clk);
    #1;
    out_ready8 = 1'b0;
    checks++;
    if ({out_valid8, in_ready8} !== 2'b01) begin
      errors++;
      $display("FAIL %s after_handshake: got vld=%b rdy=%b want vld=0 rdy=1", tag, out_valid8, in_ready8);
    end
    $display("txn8 %s: %0d / %0d -> q=%0d r=%0d z=%b lat=%0d", tag, e.a, e.b, quotient8, remainder8, dbz8, lat);
  endtask

  task automatic test_divide();
    do_div8("div_100_7", 8'd100, 8'd7, 0);
  endtask

  task automatic test_div_by_zero();
    do_div8("dbz_200_0", 8'd200, 8'd0, 0);
  endtask

  task automatic test_boundaries();
    logic [7:0] as [4] = '{8'd255, 8'd5, 8'd255, 8'd0};
    logic [7:0] bs [4] = '{8'd1,   8'd9, 8'd255, 8'd3};
    for (int i = 0; i < 4; i++) do_div8($sformatf("bound%0d", i), as[i], bs[i], 0);
  endtask

  task automatic test_backpressure();
    do_div8("bp_100_7", 8'd100, 8'd7, 5);
    checks++;
    if (sb8.size() != 0) begin
      errors++;
      $display("FAIL bp_queue: got %0d pending want 0", sb8.size());
    end
    do_div8("bp_50_6", 8'd50, 8'd6, 0);
  endtask

  task automatic test_reset_mid_calc();
    int seen;
    in_valid8 = 1'b1; dividend8 = 8'd100; divisor8 = 8'd7;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid8, in_ready8, quotient8, remainder8, dbz8} !== {1'b0, 1'b1, 8'h00, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL rst_mid_calc: got vld=%b rdy=%b q=%0d r=%0d z=%b want vld=0 rdy=1 q=0 r=0 z=0",
               out_valid8, in_ready8, quotient8, remainder8, dbz8);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid8 === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_no_result: got out_valid in %0d cycles want 0", seen);
    end
    do_div8("rst_9_2", 8'd9, 8'd2, 0);
  endtask

  task automatic do_div16(input int idx, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int lat;
    int dly;
    e.a = a; e.b = b;
    if (b == 16'd0) begin
      e.q = 16'hFFFF; e.r = a; e.z = 1'b1; e.lat = 1;
    end else begin
      e.q = a / b; e.r = a % b; e.z = 1'b0; e.lat = 5;
    end
    sb16.push_back(e);
    in_valid16 = 1'b1; dividend16 = a; divisor16 = b;
    @(posedge clk);
    #1;
    in_valid16 = 1'b0; dividend16 = 16'($urandom); divisor16 = 16'($urandom);
    lat = 1;
    while (out_valid16 !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checks++;
    if (lat != e.lat) begin
      errors++;
      $display("FAIL rnd%0d latency: got %0d edges want %0d", idx, lat, e.lat);
    end
    dly = $urandom_range(0, 2);
    repeat (dly) begin
      @(posedge clk);
      #1;
    end
    e = sb16.pop_front();
    checks++;
    if ({quotient16, remainder16, dbz16} !== {e.q, e.r, e.z}) begin
      errors++;
      $display("FAIL rnd%0d result %0d/%0d: got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b",
               idx, e.a, e.b, quotient16, remainder16, dbz16, e.q, e.r, e.z);
    end
    if (e.b != 16'd0) begin
      checks++;
      if ((32'(quotient16) * 32'(e.b) + 32'(remainder16) != 32'(e.a)) || (remainder16 >= e.b)) begin
        errors++;
        $display("FAIL rnd%0d invariant: got q*d+r=%0d r=%0d want %0d with r<%0d",
                 idx, 32'(quotient16) * 32'(e.b) + 32'(remainder16), remainder16, e.a, e.b);
      end
    end
    out_ready16 = 1'b1;
    @(posedge clk);
    #1;
    out_ready16 = 1'b0;
    checks++;
    if ({out_valid16, in_ready16} !== 2'b01) begin
      errors++;
      $display("FAIL rnd%0d after_handshake: got vld=%b rdy=%b want vld=0 rdy=1", idx, out_valid16, in_ready16);
    end
    $display("txn16 %0d: %0d / %0d -> q=%0d r=%0d z=%b lat=%0d", idx, e.a, e.b, quotient16, remainder16, dbz16, lat);
  endtask

  task automatic test_random16();
    logic [15:0] a, b;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      if ($urandom_range(0, 9) == 0) b = 16'd0;
      else b = 16'($urandom) >> $urandom_range(0, 15);
      do_div16(i, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_div_by_zero();
    test_boundaries();
    test_backpressure();
    test_reset_mid_calc();
    test_random16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
